screen_sequencer: RTL and testbench
===================================

// Module: screen_sequencer
// PURPOSE
//  Top-level scene controller for the game display: sequences TITLE -> PLAY -> OVER -> TITLE.
//  Generates one shared address for the 600x450 full-screen image ROMs (title, game-over).
//  Selects the pixel source for the VGA path, and gates/restarts the game logic.
//  Sits between the VGA timing block, the game core and the image ROMs.
// PARAMETERS
//  WIN_X0        20     left edge of image window (pixels)
//  WIN_Y0        15     top edge of image window (lines)
//  WIN_W         600    image width
//  WIN_H         450    image height
//  HOLD_FRAMES   60     frames OVER must be shown before confirm is accepted
//  AUTO_FRAMES   600    frames in OVER before auto-return (only with SCREEN_AUTO_RETURN_EN)
//  BORDER_COLOR  12'h000 colour outside the window in TITLE/OVER
// PORTS
//  clk           in   1   pixel/system clock
//  rst           in   1   asynchronous, active-high reset
//  frame_tick    in   1   one-cycle pulse per frame (start of vsync)
//  over          in   1   game core reports game over (level)
//  movement      in   6   button levels; bits [4],[5] = confirm
//  x             in   10  current VGA column
//  y             in   9   current VGA row
//  play_color    in   12  pixel from game renderer, aligned with x/y
//  title_data    in   12  title ROM douta (1-cycle read latency)
//  end_data      in   12  game-over ROM douta (1-cycle read latency)
//  rom_addr      out  19  shared ROM address = (y-WIN_Y0)*WIN_W + (x-WIN_X0)
//  color         out  12  pixel to VGA output
//  state         out  2   current scene (TITLE=0, PLAY=1, OVER=2)
//  game_run      out  1   high only in PLAY; enables game core
//  game_restart  out  1   one-cycle pulse on TITLE->PLAY
// BEHAVIOUR
//  Reset: state=TITLE, color=0, rom_addr=0, game_run=0, game_restart=0, frame_cnt=0.
//  Reset: confirm history = 1, so a button held through reset never triggers.
//  Confirm = rising edge of (movement[4]|movement[5]), sampled every clk.
//  TITLE: on confirm -> PLAY; game_restart=1 for exactly that transition cycle.
//  PLAY: game_run=1; over=1 -> OVER, frame_cnt cleared.
//   If over and confirm arrive in the same cycle, over wins.
//  OVER: frame_cnt++ on frame_tick, saturating. Confirm ignored while frame_cnt<HOLD_FRAMES.
//   Once frame_cnt>=HOLD_FRAMES, confirm -> TITLE.
//  Pixel pipeline, fixed 3-cycle latency x/y -> color in every state:
//   c1: inwin = (x-WIN_X0)<WIN_W && (y-WIN_Y0)<WIN_H. The subtractions are unsigned 10-bit;
//       wrap below the origin makes them large, so the pixel counts as outside.
//       rom_addr registered; rom_addr held at 0 when outside the window.
//   c2: ROM data valid; inwin and play_color delayed to match.
//   c3: color register loads from the scene state in that cycle:
//       TITLE -> title_data or BORDER_COLOR; OVER -> end_data or BORDER_COLOR;
//       PLAY  -> play_color delayed 2 cycles.
//  Multiply y*600 done as (y<<9)+(y<<6)+(y<<4)+(y<<3); result width 19 bits, max 269999.
//  State change mid-line: color switches source on the next c3 edge; no blanking inserted.
//  rst asserted mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  SCREEN_AUTO_RETURN_EN defined: in OVER, frame_cnt>=AUTO_FRAMES -> TITLE without confirm.
//  SCREEN_AUTO_RETURN_EN undefined: OVER is left only by confirm; AUTO_FRAMES unused.
// STRUCTURE
//  screen_pkg: state encodings S_TITLE/S_PLAY/S_OVER, WIN_* defaults, COLOR_W=12, ADDR_W=19.
//  Sub-module screen_addr_gen: window test + address pipeline (c1/c2) + inwin delay.
//  Top level holds the FSM, confirm edge detect, frame counter and the colour mux.
// TESTING
//  1 Reset with movement[4]=1 held, then release and press again
//    -> no PLAY until the second press; game_restart pulses once.
//  2 x=20,y=15 -> rom_addr=0; x=619,y=464 -> rom_addr=269999; x=19 -> inwin=0.
//    Also x=620 -> inwin=0. Color appears 3 clk after x/y.
//  3 In PLAY, pulse over and confirm in the same cycle -> state=OVER, game_run=0 next cycle.
//  4 In OVER, press confirm at frame 59 -> stays OVER. Press at frame 60 -> TITLE.
//  5 SCREEN_AUTO_RETURN_EN: sit in OVER 600 frame_ticks, no buttons -> TITLE.
//    Without the macro -> still OVER after 1000 frame_ticks.
//  6 Assert rst while in PLAY mid-line -> state=0, color=12'h000, game_run=0 without waiting for clk.

Source files
------------

// File: rtl/screen_pkg.sv
// screen_pkg: scene encodings, image window geometry and widths for screen_sequencer.
package screen_pkg;
  localparam int COLOR_W = 12;
  localparam int ADDR_W = 19;
  localparam int CNT_W = 10;
  localparam logic [9:0] WIN_X0 = 10'd20;
  localparam logic [9:0] WIN_Y0 = 10'd15;
  localparam logic [9:0] WIN_W = 10'd600;
  localparam logic [9:0] WIN_H = 10'd450;
  localparam logic [CNT_W-1:0] HOLD_FRAMES = 10'd60;
  localparam logic [CNT_W-1:0] AUTO_FRAMES = 10'd600;
  localparam logic [COLOR_W-1:0] BORDER_COLOR = 12'h000;
  typedef enum logic [1:0] {
    S_TITLE = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2
  } state_t;
endpackage

// File: rtl/screen_addr_gen.sv
// screen_addr_gen: image window test and shared ROM address (c1), window flag delayed to the ROM data (c2).
module screen_addr_gen import screen_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x_i,
  input  logic [8:0]        y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              inwin_o
);
  logic [9:0] dx, dy;
  logic inwin;
  logic [ADDR_W-1:0] dy_w, addr_d, addr_q;
  logic inwin1_q, inwin2_q;
  // wrap below the origin makes dx/dy huge, so the window test also rejects those pixels
  assign dx = x_i - WIN_X0;
  assign dy = {1'b0, y_i} - WIN_Y0;
  assign inwin = (dx < WIN_W) && (dy < WIN_H);
  assign dy_w = ADDR_W'(dy);
  assign addr_d = inwin ? (dy_w << 9) + (dy_w << 6) + (dy_w << 4) + (dy_w << 3) + ADDR_W'(dx) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      inwin1_q <= 1'b0;
      inwin2_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      inwin1_q <= inwin;
      inwin2_q <= inwin1_q;
    end
  end
  assign addr_o = addr_q;
  assign inwin_o = inwin2_q;
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: TITLE -> PLAY -> OVER scene FSM, shared image ROM addressing and pixel source mux.
// Define SCREEN_AUTO_RETURN_EN to leave OVER automatically after AUTO_FRAMES frames.
module screen_sequencer import screen_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               over,
  input  logic [5:0]         movement,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  input  logic [COLOR_W-1:0] play_color,
  input  logic [COLOR_W-1:0] title_data,
  input  logic [COLOR_W-1:0] end_data,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [COLOR_W-1:0] color,
  output logic [1:0]         state,
  output logic               game_run,
  output logic               game_restart
);
  state_t state_q;
  logic btn_q, game_run_q, game_restart_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [COLOR_W-1:0] play1_q, play2_q, color_q, color_d;
  logic inwin, btn, confirm, auto_ret, unused_ok;
  screen_addr_gen u_addr (
    .clk     (clk),
    .rst     (rst),
    .x_i     (x),
    .y_i     (y),
    .addr_o  (rom_addr),
    .inwin_o (inwin)
  );
  assign unused_ok = ^movement[3:0];
  assign btn = movement[4] | movement[5];
  assign confirm = btn & ~btn_q;
`ifdef SCREEN_AUTO_RETURN_EN
  assign auto_ret = frame_cnt_q >= AUTO_FRAMES;
`else
  assign auto_ret = 1'b0;
`endif
  // btn_q resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_TITLE;
      btn_q <= 1'b1;
      frame_cnt_q <= '0;
      game_run_q <= 1'b0;
      game_restart_q <= 1'b0;
    end else begin
      btn_q <= btn;
      game_restart_q <= 1'b0;
      case (state_q)
        S_TITLE: if (confirm) begin
          state_q <= S_PLAY;
          game_run_q <= 1'b1;
          game_restart_q <= 1'b1;
        end
        S_PLAY: if (over) begin
          state_q <= S_OVER;
          game_run_q <= 1'b0;
          frame_cnt_q <= '0;
        end
        S_OVER: begin
          if (frame_tick && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
          if ((confirm && frame_cnt_q >= HOLD_FRAMES) || auto_ret) state_q <= S_TITLE;
        end
        default: begin
          state_q <= S_TITLE;
          game_run_q <= 1'b0;
        end
      endcase
    end
  end
  assign color_d = state_q == S_PLAY ? play2_q : !inwin ? BORDER_COLOR : state_q == S_OVER ? end_data : title_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play1_q <= '0;
      play2_q <= '0;
      color_q <= '0;
    end else begin
      play1_q <= play_color;
      play2_q <= play1_q;
      color_q <= color_d;
    end
  end
  assign color = color_q;
  assign state = state_q;
  assign game_run = game_run_q;
  assign game_restart = game_restart_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: random pixel/button stimulus checked every cycle against a scene-level reference model.
module tb_screen_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic over = 1'b0;
  logic [5:0] movement = 6'h10;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [11:0] play_color = '0, title_data = '0, end_data = '0;
  logic [18:0] rom_addr;
  logic [11:0] color;
  logic [1:0] state;
  logic game_run, game_restart;
  int total = 0;
  int bad = 0;

  typedef struct {int px; int py; int pc;} pix_t;
  pix_t hist[$];
  int m_state, m_prev, m_cnt, m_restart;

  always #5 clk = ~clk;

  screen_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .over         (over),
    .movement     (movement),
    .x            (x),
    .y            (y),
    .play_color   (play_color),
    .title_data   (title_data),
    .end_data     (end_data),
    .rom_addr     (rom_addr),
    .color        (color),
    .state        (state),
    .game_run     (game_run),
    .game_restart (game_restart)
  );

  function automatic int tf(int a);
    return (a * 37 + 5) & 'hfff;
  endfunction
  function automatic int ef(int a);
    return ((a >> 3) ^ 'h5a5) & 'hfff;
  endfunction
  function automatic bit win(pix_t p);
    int dx = (p.px - 20) & 1023;
    int dy = (p.py - 15) & 1023;
    return dx < 600 && dy < 450;
  endfunction
  function automatic int addr(pix_t p);
    return win(p) ? ((p.py - 15) * 600 + (p.px - 20)) : 0;
  endfunction

  // image ROMs with one cycle of read latency
  always @(posedge clk) begin
    title_data <= 12'(tf(int'(rom_addr)));
    end_data <= 12'(ef(int'(rom_addr)));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prev = 1;
    m_cnt = 0;
    m_restart = 0;
    hist.delete();
    repeat (3) hist.push_back('{0, 0, 0});
  endtask

  task automatic rnd_pix();
    x = 10'($urandom_range(0, 799));
    y = 9'($urandom_range(0, 511));
    play_color = 12'($urandom);
  endtask

  task automatic tick();
    pix_t p;
    int e_color, old;
    bit btn, conf, leave;
    @(posedge clk);
    p.px = int'(x);
    p.py = int'(y);
    p.pc = int'(play_color);
    hist.push_back(p);
    if (hist.size() > 3) void'(hist.pop_front());
    e_color = m_state == 1 ? hist[0].pc : !win(hist[0]) ? 0 :
              m_state == 2 ? ef(addr(hist[0])) : tf(addr(hist[0]));
    btn = movement[4] || movement[5];
    conf = btn && m_prev == 0;
    m_prev = btn;
    m_restart = 0;
    if (m_state == 0) begin
      if (conf) begin
        m_state = 1;
        m_restart = 1;
      end
    end else if (m_state == 1) begin
      if (over) begin
        m_state = 2;
        m_cnt = 0;
      end
    end else begin
      old = m_cnt;
      if (frame_tick && m_cnt < 1023) m_cnt++;
      leave = conf && old >= 60;
`ifdef SCREEN_AUTO_RETURN_EN
      leave = leave || old >= 600;
`endif
      if (leave) m_state = 0;
    end
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("game_run", 32'(game_run), 32'(m_state == 1));
    chk("game_restart", 32'(game_restart), 32'(m_restart));
    chk("rom_addr", 32'(rom_addr), 32'(addr(p)));
    chk("color", 32'(color), 32'(e_color));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_color"}, 32'(color), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
    chk({tag, "_game_run"}, 32'(game_run), 0);
    chk({tag, "_game_restart"}, 32'(game_restart), 0);
  endtask

  int dir_x[6] = '{20, 619, 19, 620, 20, 619};
  int dir_y[6] = '{15, 464, 15, 15, 14, 465};
  int dir_a[6] = '{0, 269999, 0, 0, 0, 0};

  initial begin
    model_reset();
    rnd_pix();
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      rnd_pix();
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      x = 10'(dir_x[i]);
      y = 9'(dir_y[i]);
      tick();
      chk("addr_dir", 32'(rom_addr), 32'(dir_a[i]));
    end
    repeat (3) tick();
    movement = 6'h00;
    tick();
    movement = 6'h10;
    tick();
    chk("first_press", 32'(state), 1);
    movement = 6'h00;
    repeat (10) begin
      rnd_pix();
      tick();
    end
    movement = 6'h20;
    over = 1'b1;
    tick();
    chk("over_wins", 32'(state), 2);
    over = 1'b0;
    movement = 6'h00;
    tick();
    chk("over_run", 32'(game_run), 0);
    frame_tick = 1'b1;
    repeat (59) begin
      rnd_pix();
      tick();
    end
    frame_tick = 1'b0;
    movement = 6'h10;
    tick();
    chk("hold59", 32'(state), 2);
    movement = 6'h00;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    movement = 6'h10;
    tick();
    chk("hold60", 32'(state), 0);
    movement = 6'h00;
    tick();
    movement = 6'h10;
    tick();
    movement = 6'h00;
    over = 1'b1;
    tick();
    over = 1'b0;
    frame_tick = 1'b1;
    repeat (1000) begin
      rnd_pix();
      tick();
    end
    frame_tick = 1'b0;
    tick();
`ifdef SCREEN_AUTO_RETURN_EN
    chk("auto_return", 32'(state), 0);
`else
    chk("no_auto_return", 32'(state), 2);
`endif
    repeat (2) begin
      movement = 6'h20;
      tick();
      movement = 6'h00;
      tick();
    end
    chk("replay", 32'(state), 1);
    repeat (5) begin
      rnd_pix();
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (600) begin
      rnd_pix();
      movement = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 4'($urandom)};
      over = $urandom_range(0, 19) == 0;
      frame_tick = $urandom_range(0, 1) == 1;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
